mem_seq_ctrl: RTL and testbench
===============================

// Module: mem_seq_ctrl
// PURPOSE
// - Multi-cycle sequencer for the unified single-port 32x32 program/data memory.
// - Owns the memory address/write port and shares it between a preload port
//   (testbench/loader, IDLE only) and the fetch/operand-read sequence.
// - Implements fetch -> decode -> operand read -> branch/jump resolve and owns PC.
// PARAMETERS
// - ADDR_W       5   memory address width; PC width; PC wraps mod 2**ADDR_W
// - DATA_W       32  memory word / instruction width
// - RESET_PC     0   PC value after reset
// - HALT_OPCODE  63  opcode that stops the sequencer
// PORTS
// - clk         in   1       clock, all state changes on posedge
// - reset       in   1       reset, synchronous, active-high
// - run         in   1       level; 1 = execute program, 0 = return to IDLE after current instr
// - load_valid  in   1       preload write request
// - load_ready  out  1       preload accepted this cycle (valid & ready = write)
// - load_addr   in   ADDR_W  preload address
// - load_data   in   DATA_W  preload data
// - mem_addr    out  ADDR_W  memory address (combinational from state)
// - mem_we      out  1       memory write enable
// - mem_wdata   out  DATA_W  memory write data
// - mem_rdata   in   DATA_W  memory read data, valid the cycle after mem_addr (sync read)
// - pc          out  ADDR_W  program counter
// - state       out  3       FSM state encoding (debug)
// - op_a        out  DATA_W  latched mem[rs]
// - op_b        out  DATA_W  latched mem[rd]
// - taken       out  1       1-cycle pulse: branch/jump redirected PC
// - halted      out  1       1 while in HALTED
// BEHAVIOUR
// - Instr fields: opcode[31:26], rd[25:21], rs[20:16], imm[15:0], target[25:0].
// - States: IDLE=0, FETCH=1, DECODE=2, OPA=3, OPB=4, EXEC=5, HALTED=6.
// - Reset: state=IDLE, pc=RESET_PC, ir=0, op_a=0, op_b=0, taken=0, halted=0,
//   mem_we=0; reset mid-instruction aborts it, memory contents untouched.
// - IDLE: load_ready=1, mem_addr=load_addr, mem_we=load_valid, mem_wdata=load_data.
//   If load_valid: write this cycle, stay IDLE (load wins over run). Else if run: -> FETCH.
// - Outside IDLE: load_ready=0, mem_we=0; preload requests are held off, not dropped.
// - FETCH: mem_addr=pc -> DECODE.
// - DECODE: ir<=mem_rdata. opcode 14..19 -> OPA; opcode==HALT_OPCODE -> HALTED;
//   all others (incl. 20,21) -> EXEC.
// - OPA: mem_addr=ir.rs -> OPB.   OPB: mem_addr=ir.rd, op_a<=mem_rdata -> EXEC.
// - EXEC (branch): op_b<=mem_rdata; compare op_a vs mem_rdata, unsigned:
//   14 eq, 15 ne, 16 gt, 17 ge, 18 lt, 19 le.
//   taken: pc<=pc+1+imm[ADDR_W-1:0]; else pc<=pc+1.
// - EXEC (20/21 jump): pc<=target[ADDR_W-1:0], taken=1. Other opcodes: NOP, pc<=pc+1.
// - PC arithmetic is ADDR_W bits, wraps silently (31+1=0; 30+1+3=2).
// - EXEC exit: run=1 -> FETCH; run=0 -> IDLE. run drop never aborts an instruction.
// - Latency: branch 5 cycles (FETCH..EXEC), jump/NOP 3 cycles, posedge to pc update.
// - taken asserted only in the cycle after EXEC, 0 otherwise.
// - HALTED: halted=1, pc frozen at halt instr address; run=0 -> IDLE; stays otherwise.
// - mem_addr in DECODE/EXEC/HALTED = pc (don't-care read, deterministic for waves).
// TESTING
// - Preload mem[0]=opcode14 rd=29 rs=31 imm=2, mem[29]=4, mem[31]=4; run=1
//   -> op_a=op_b=4, taken pulse, pc=3 five cycles after leaving IDLE.
// - Same with mem[29]=5 -> not taken, pc=1; opcode 16 with 5 vs 4 (rs=5, rd=4) -> not taken.
// - mem[3]=opcode20 target=9 -> pc=9 three cycles after FETCH, taken=1 for 1 cycle.
// - pc=31 NOP -> pc=0; branch at pc=30 imm=3 taken -> pc=2 (wrap).
// - mem[9]=opcode63 -> halted=1, pc=9 held 10 cycles; run=0 -> IDLE, load_ready=1.
// - load_valid held during run -> load_ready=0, no mem_we; reset during OPB
//   -> next cycle IDLE, pc=0, op_a=0, preload memory retained.

Source files
------------

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: multi-cycle fetch/decode/operand/branch sequencer that owns the
// single-port unified program/data memory and the program counter.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   run               level: 1 = execute, 0 = drop to IDLE after current instr
//   load_valid/ready  preload handshake, only serviced in IDLE
//   load_addr/data    preload write address / data
//   mem_addr/we/wdata memory port (combinational from state)
//   mem_rdata         memory read data, one cycle after mem_addr
//   pc                program counter
//   state             FSM state (debug)
//   op_a, op_b        latched mem[rs], mem[rd] of the last branch
//   taken             one-cycle pulse after a redirecting branch/jump
//   halted            high while halted
module mem_seq_ctrl #(
  parameter int                ADDR_W      = 5,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                HALT_OPCODE = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              taken,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    OPA    = 3'd3,
    OPB    = 3'd4,
    EXEC   = 3'd5,
    HALTED = 3'd6
  } state_t;

  state_t            st, st_nxt;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc_nxt;
  logic              cond, redirect;

  // Decode looks at the word arriving from memory; later states use the IR.
  logic [5:0]        dec_op, ir_op;
  logic [ADDR_W-1:0] ir_rd, ir_rs, ir_low;
  logic              dec_br, ir_br, ir_jmp;
  logic              unused_ir;

  assign dec_op    = mem_rdata[31:26];
  assign ir_op     = ir[31:26];
  assign ir_rd     = ir[21 +: ADDR_W];
  assign ir_rs     = ir[16 +: ADDR_W];
  assign ir_low    = ir[ADDR_W-1:0];   // imm and target share the low bits
  assign unused_ir = ^ir[15:ADDR_W];
  assign dec_br    = (dec_op >= 6'd14) && (dec_op <= 6'd19);
  assign ir_br     = (ir_op >= 6'd14) && (ir_op <= 6'd19);
  assign ir_jmp    = (ir_op == 6'd20) || (ir_op == 6'd21);

  // Branch compare: op_a (mem[rs]) against mem[rd] arriving this cycle.
  always_comb begin
    cond = 1'b0;
    case (ir_op)
      6'd14: cond = (op_a == mem_rdata);
      6'd15: cond = (op_a != mem_rdata);
      6'd16: cond = (op_a >  mem_rdata);
      6'd17: cond = (op_a >= mem_rdata);
      6'd18: cond = (op_a <  mem_rdata);
      6'd19: cond = (op_a <= mem_rdata);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    redirect = ir_jmp || (ir_br && cond);
    if (ir_jmp)            pc_nxt = ir_low;
    else if (ir_br && cond) pc_nxt = pc + ADDR_W'(1) + ir_low;
    else                   pc_nxt = pc + ADDR_W'(1);
  end

  always_comb begin
    st_nxt     = st;
    mem_addr   = pc;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    load_ready = 1'b0;
    case (st)
      IDLE: begin
        // Gate on reset so a preload can never land while reset is asserted.
        load_ready = ~reset;
        mem_addr   = load_addr;
        mem_we     = load_valid & ~reset;
        mem_wdata  = load_data;
        if (load_valid)  st_nxt = IDLE;
        else if (run)    st_nxt = FETCH;
      end
      FETCH:  st_nxt = DECODE;
      DECODE: begin
        if (dec_br)                           st_nxt = OPA;
        else if (dec_op == 6'(HALT_OPCODE))   st_nxt = HALTED;
        else                                  st_nxt = EXEC;
      end
      OPA: begin
        mem_addr = ir_rs;
        st_nxt   = OPB;
      end
      OPB: begin
        mem_addr = ir_rd;
        st_nxt   = EXEC;
      end
      EXEC:   st_nxt = run ? FETCH : IDLE;
      HALTED: if (!run) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      taken <= 1'b0;
    end else begin
      st    <= st_nxt;
      taken <= 1'b0;
      case (st)
        DECODE: ir   <= mem_rdata;
        OPB:    op_a <= mem_rdata;
        EXEC: begin
          if (ir_br) op_b <= mem_rdata;
          pc    <= pc_nxt;
          taken <= redirect;
        end
        default: ;
      endcase
    end
  end

  assign state  = st;
  assign halted = (st == HALTED);

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: provides a sync-read 32x32 memory,
// an instruction-level reference model, directed scenarios and random programs.
module tb_mem_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset, run, load_valid, load_ready;
  logic [4:0]  load_addr, mem_addr, pc;
  logic [31:0] load_data, mem_wdata, mem_rdata, op_a, op_b;
  logic        mem_we, taken, halted;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  mem_seq_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .load_valid(load_valid),
    .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pc(pc), .state(state), .op_a(op_a), .op_b(op_b),
    .taken(taken), .halted(halted)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory (environment, not reference).
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model state: instruction-level view of the machine.
  logic [31:0] ref_mem [32];
  logic [4:0]  m_pc;
  logic [31:0] m_opa, m_opb;
  logic        m_taken;

  function automatic logic [31:0] mk(int op, int rd, int rs, int imm);
    logic [5:0] o = 6'(op);
    logic [4:0] d = 5'(rd);
    logic [4:0] s = 5'(rs);
    logic [15:0] i = 16'(imm);
    return {o, d, s, i};
  endfunction

  function automatic logic [31:0] mkj(int op, int tgt);
    logic [5:0] o = 6'(op);
    logic [25:0] t = 26'(tgt);
    return {o, t};
  endfunction

  function automatic logic [31:0] rand_word();
    int k = $urandom_range(0, 9);
    logic [5:0] op;
    logic [25:0] f = 26'($urandom);
    if (k < 6)       op = 6'(14 + k);
    else if (k == 6) op = 6'd20;
    else if (k == 7) op = 6'd21;
    else             op = 6'($urandom_range(22, 62));
    return {op, f};
  endfunction

  // Execute one instruction at m_pc; returns cycles from FETCH to pc update.
  task automatic model_step(output int lat);
    logic [31:0] w = ref_mem[m_pc];
    int op = int'(w[31:26]);
    longint a, b;
    bit c;
    m_taken = 1'b0;
    if (op >= 14 && op <= 19) begin
      a = longint'(ref_mem[w[20:16]]);
      b = longint'(ref_mem[w[25:21]]);
      m_opa = ref_mem[w[20:16]];
      m_opb = ref_mem[w[25:21]];
      case (op)
        14: c = (a == b);
        15: c = (a != b);
        16: c = (a > b);
        17: c = (a >= b);
        18: c = (a < b);
        default: c = (a <= b);
      endcase
      m_taken = c;
      if (c) m_pc = 5'((int'(m_pc) + 1 + int'(w[15:0])) % 32);
      else   m_pc = 5'((int'(m_pc) + 1) % 32);
      lat = 5;
    end else if (op == 20 || op == 21) begin
      m_pc = 5'(w[25:0] % 32);
      m_taken = 1'b1;
      lat = 3;
    end else begin
      m_pc = 5'((int'(m_pc) + 1) % 32);
      lat = 3;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; load_valid = 1'b0;
    tick();
    reset = 1'b0;
    m_pc = 5'd0; m_opa = '0; m_opb = '0; m_taken = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_valid = 1'b1; load_addr = 5'(a); load_data = d;
    #1;
    checks++;
    if ({load_ready, mem_we} !== 2'b11) begin
      failures++;
      $display("FAIL load_handshake addr=%0d got ready/we=%b expected 11", a, {load_ready, mem_we});
    end
    tick();
    load_valid = 1'b0;
    ref_mem[a] = d;
  endtask

  // Single-step one instruction from IDLE and check latency and results.
  task automatic exec_one(input string name);
    int lat;
    logic [4:0] pc0 = m_pc;
    model_step(lat);
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL %s_fetch state=%0d expected 1", name, state);
    end
    repeat (lat - 1) tick();
    checks++;
    if ({state, pc, taken} !== {3'd5, pc0, 1'b0}) begin
      failures++;
      $display("FAIL %s_exec state/pc/taken=%0d/%0d/%b expected 5/%0d/0", name, state, pc, taken, pc0);
    end
    tick();
    checks++;
    if ({state, pc, taken, op_a, op_b} !== {3'd0, m_pc, m_taken, m_opa, m_opb}) begin
      failures++;
      $display("FAIL %s_done state=%0d pc=%0d taken=%b op_a=%0h op_b=%0h expected 0/%0d/%b/%0h/%0h",
               name, state, pc, taken, op_a, op_b, m_pc, m_taken, m_opa, m_opb);
    end
    tick();
    checks++;
    if (taken !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse taken=%b expected 0", name, taken);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    tick(); tick();
    reset = 1'b0;
    m_pc = 5'd0; m_opa = '0; m_opb = '0; m_taken = 1'b0;
    #1;
    checks++;
    if ({state, pc, op_a, op_b, taken, halted, load_ready, mem_we} !== {3'd0, 5'd0, 64'd0, 4'b0010}) begin
      failures++;
      $display("FAIL reset state=%0d pc=%0d op_a=%0h op_b=%0h taken=%b halted=%b ready=%b we=%b",
               state, pc, op_a, op_b, taken, halted, load_ready, mem_we);
    end
  endtask

  task automatic test_branch();
    load(0, mk(14, 29, 31, 2)); load(29, 32'd4); load(31, 32'd4);
    exec_one("beq_taken");
    do_reset();
    load(29, 32'd5);
    exec_one("beq_not_taken");
    do_reset();
    load(0, mk(16, 4, 5, 2)); load(5, 32'd4); load(4, 32'd5);
    exec_one("bgt_not_taken");
  endtask

  task automatic test_jump_wrap();
    do_reset();
    load(0, mk(14, 1, 1, 2)); load(1, 32'd7); load(3, mkj(20, 9));
    load(9, mkj(21, 30)); load(30, mk(14, 1, 1, 3));
    load(2, mkj(20, 31)); load(31, mk(5, 0, 0, 0));
    exec_one("br_to_3");
    exec_one("jump_9");
    exec_one("jump_30");
    exec_one("branch_wrap");
    exec_one("jump_31");
    exec_one("nop_wrap");
  endtask

  task automatic test_halt();
    do_reset();
    load(0, mkj(20, 9)); load(9, mk(63, 0, 0, 0));
    exec_one("jump_to_halt");
    run = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({halted, state, pc} !== {1'b1, 3'd6, 5'd9}) begin
        failures++;
        $display("FAIL halt_hold cyc=%0d halted/state/pc=%b/%0d/%0d expected 1/6/9", i, halted, state, pc);
      end
      tick();
    end
    run = 1'b0;
    tick();
    checks++;
    if ({halted, state, pc, load_ready} !== {1'b0, 3'd0, 5'd9, 1'b1}) begin
      failures++;
      $display("FAIL halt_exit halted/state/pc/ready=%b/%0d/%0d/%b expected 0/0/9/1", halted, state, pc, load_ready);
    end
  endtask

  task automatic test_load_holdoff();
    int lat;
    do_reset();
    load(0, mk(5, 0, 0, 0));
    model_step(lat);
    run = 1'b1;
    tick();
    run = 1'b0;
    load_valid = 1'b1; load_addr = 5'd20; load_data = 32'hCAFE_0020;
    for (int i = 0; i < lat; i++) begin
      #1;
      checks++;
      if ({load_ready, mem_we} !== 2'b00) begin
        failures++;
        $display("FAIL holdoff cyc=%0d ready/we=%b expected 00", i, {load_ready, mem_we});
      end
      tick();
    end
    #1;
    checks++;
    if ({state, pc, load_ready, mem_we} !== {3'd0, m_pc, 2'b11}) begin
      failures++;
      $display("FAIL holdoff_release state/pc/ready/we=%0d/%0d/%b expected 0/%0d/11", state, pc, {load_ready, mem_we}, m_pc);
    end
    tick();
    load_valid = 1'b0;
    ref_mem[20] = 32'hCAFE_0020;
    checks++;
    if (mem[20] !== 32'hCAFE_0020) begin
      failures++;
      $display("FAIL holdoff_write mem20=%0h expected cafe0020", mem[20]);
    end
  endtask

  task automatic test_reset_mid();
    bit same = 1'b1;
    load(1, mk(15, 2, 3, 4)); load(2, 32'hBB); load(3, 32'hAA);
    load(6, mk(17, 2, 3, 1));
    exec_one("bne_taken");
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (state !== 3'd4) begin
      failures++;
      $display("FAIL mid_opb state=%0d expected 4", state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pc = 5'd0; m_opa = '0; m_opb = '0;
    checks++;
    if ({state, pc, op_a, op_b, taken} !== {3'd0, 5'd0, 64'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset state=%0d pc=%0d op_a=%0h op_b=%0h taken=%b", state, pc, op_a, op_b, taken);
    end
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) same = 1'b0;
    checks++;
    if (!same) begin
      failures++;
      $display("FAIL mid_reset_mem contents changed got=%0h expected=%0h", mem[6], ref_mem[6]);
    end
  endtask

  task automatic test_random();
    int lat;
    do_reset();
    for (int i = 0; i < 32; i++) load(i, rand_word());
    for (int i = 0; i < 15; i++) exec_one("rand_step");
    run = 1'b1;
    tick();
    for (int i = 0; i < 25; i++) begin
      model_step(lat);
      if (i == 24) run = 1'b0;
      repeat (lat) tick();
      checks++;
      if ({pc, taken, op_a, op_b} !== {m_pc, m_taken, m_opa, m_opb}) begin
        failures++;
        $display("FAIL back_to_back i=%0d pc=%0d taken=%b op_a=%0h op_b=%0h expected %0d/%b/%0h/%0h",
                 i, pc, taken, op_a, op_b, m_pc, m_taken, m_opa, m_opb);
      end
    end
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL back_to_back_idle state=%0d expected 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_wrap();
    test_halt();
    test_load_holdoff();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
